npc_ai_controller: RTL and testbench



---
 rtl/ff_ai_pkg.sv | 47 ++++
 rtl/frame_tick_sync.sv | 29 ++
 rtl/npc_ai_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_npc_ai_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_ai_pkg.sv
// Shared types and default constants for the NPC AI controller.
// Holds the FSM state encoding (also exposed on state_dbg) and the LFSR definition.
package ff_ai_pkg;

    localparam int CNT_W = 8;
    localparam int POS_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_OBSERVE  = 3'd1,
        ST_APPROACH = 3'd2,
        ST_RETREAT  = 3'd3,
        ST_JUMP     = 3'd4,
        ST_FIRE     = 3'd5
    } npc_ai_state_t;

    localparam logic [CNT_W-1:0] DEF_DECIDE_FRAMES = 8'd8;
    localparam logic [CNT_W-1:0] DEF_MOVE_FRAMES   = 8'd16;
    localparam logic [CNT_W-1:0] DEF_JUMP_FRAMES   = 8'd2;
    localparam logic [CNT_W-1:0] DEF_FIRE_COOLDOWN = 8'd90;

    localparam logic [POS_W-1:0] DEF_NEAR_DIST = 10'd40;
    localparam logic [POS_W-1:0] DEF_FAR_DIST  = 10'd120;
    localparam logic [POS_W-1:0] DEF_X_MIN     = 10'd10;
    localparam logic [POS_W-1:0] DEF_X_MAX     = 10'd590;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

    // Magnitude of the 11-bit signed difference a - b; always fits in POS_W bits.
    function automatic logic [POS_W-1:0] abs_dist(input logic [POS_W-1:0] a,
                                                  input logic [POS_W-1:0] b);
        logic [POS_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[POS_W]) begin
            abs_dist = ~d[POS_W-1:0] + {{(POS_W-1){1'b0}}, 1'b1};
        end else begin
            abs_dist = d[POS_W-1:0];
        end
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous VGA vertical sync into the Clk domain and turns each
// rising edge into a single registered tick, three Clk cycles after the edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Two-flop synchronizer, edge history and registered edge pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            tick    <= 1'b0;
        end else begin
            sync1_r <= frame_clk;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            tick    <= sync2_r & ~prev_r;
        end
    end

endmodule

// File: rtl/npc_ai_controller.sv
// Frame-paced opponent brain: observes NPC/player spacing and drives move/jump/shoot levels.
// Define NPC_AI_RANDOM_EN to add LFSR-varied decision spacing and occasional idle jumps.
module npc_ai_controller
    import ff_ai_pkg::*;
#(
    parameter logic [CNT_W-1:0] DECIDE_FRAMES = DEF_DECIDE_FRAMES,
    parameter logic [CNT_W-1:0] MOVE_FRAMES   = DEF_MOVE_FRAMES,
    parameter logic [CNT_W-1:0] JUMP_FRAMES   = DEF_JUMP_FRAMES,
    parameter logic [CNT_W-1:0] FIRE_COOLDOWN = DEF_FIRE_COOLDOWN,
    parameter logic [POS_W-1:0] NEAR_DIST     = DEF_NEAR_DIST,
    parameter logic [POS_W-1:0] FAR_DIST      = DEF_FAR_DIST,
    parameter logic [POS_W-1:0] X_MIN         = DEF_X_MIN,
    parameter logic [POS_W-1:0] X_MAX         = DEF_X_MAX
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic             enable,
    input  logic [POS_W-1:0] NPC_X,
    input  logic [POS_W-1:0] Player_X,
    output logic             NPC_Left,
    output logic             NPC_Right,
    output logic             NPC_Up,
    output logic             NPC_Shoot,
    output logic [2:0]       state_dbg
);

    logic             tick_s;
    logic [POS_W-1:0] dist_s;
    logic             right_of_s;
    logic             at_limit_s;
    logic [CNT_W-1:0] reload_s;
    logic             idle_jump_s;

    npc_ai_state_t    state_r;
    npc_ai_state_t    nxt_state_s;
    logic [CNT_W-1:0] decide_cnt_r;
    logic [CNT_W-1:0] nxt_decide_s;
    logic [CNT_W-1:0] move_cnt_r;
    logic [CNT_W-1:0] nxt_move_s;
    logic [CNT_W-1:0] jump_cnt_r;
    logic [CNT_W-1:0] nxt_jump_s;
    logic [CNT_W-1:0] cooldown_r;
    logic [CNT_W-1:0] nxt_cool_s;
    logic             left_s;
    logic             right_s;
    logic             up_s;
    logic             shoot_s;

    frame_tick_sync u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick_s)
    );

    // Positions are only acted on in tick cycles, which is the once-per-frame sample.
    assign dist_s     = abs_dist(NPC_X, Player_X);
    assign right_of_s = (NPC_X >= Player_X);
    // Wall behind the NPC when it backs away from the player.
    assign at_limit_s = right_of_s ? (NPC_X >= X_MAX) : (NPC_X <= X_MIN);

`ifdef NPC_AI_RANDOM_EN
    logic [15:0] lfsr_r;

    // Pseudo-random source, stepped once per frame regardless of FSM state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr_r <= LFSR_SEED;
        end else if (tick_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign reload_s    = DECIDE_FRAMES + {{(CNT_W-3){1'b0}}, lfsr_r[2:0]};
    assign idle_jump_s = lfsr_r[3];
`else
    assign reload_s    = DECIDE_FRAMES;
    assign idle_jump_s = 1'b0;
`endif

    // Next-state and counter logic, applied by the register block only on ticks.
    always_comb begin
        nxt_state_s  = state_r;
        nxt_decide_s = decide_cnt_r;
        nxt_move_s   = move_cnt_r;
        nxt_jump_s   = jump_cnt_r;
        if ((state_r != ST_IDLE) && (cooldown_r != 8'd0)) begin
            nxt_cool_s = cooldown_r - 8'd1;
        end else begin
            nxt_cool_s = cooldown_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    nxt_state_s  = ST_OBSERVE;
                    nxt_decide_s = DECIDE_FRAMES;
                end else begin
                    nxt_state_s  = ST_IDLE;
                end
            end
            ST_OBSERVE: begin
                if (decide_cnt_r <= 8'd1) begin
                    nxt_decide_s = 8'd0;
                    if (dist_s < NEAR_DIST) begin
                        if (at_limit_s) begin
                            nxt_state_s = ST_JUMP;
                            nxt_jump_s  = JUMP_FRAMES;
                        end else begin
                            nxt_state_s = ST_RETREAT;
                            nxt_move_s  = MOVE_FRAMES;
                        end
                    end else if ((cooldown_r == 8'd0) && (dist_s <= FAR_DIST)) begin
                        nxt_state_s = ST_FIRE;
                    end else if (dist_s > FAR_DIST) begin
                        nxt_state_s = ST_APPROACH;
                        nxt_move_s  = MOVE_FRAMES;
                    end else if (idle_jump_s) begin
                        nxt_state_s = ST_JUMP;
                        nxt_jump_s  = JUMP_FRAMES;
                    end else begin
                        nxt_decide_s = reload_s;
                    end
                end else begin
                    nxt_decide_s = decide_cnt_r - 8'd1;
                end
            end
            ST_APPROACH: begin
                if ((dist_s <= FAR_DIST) || (move_cnt_r <= 8'd1)) begin
                    nxt_state_s  = ST_OBSERVE;
                    nxt_decide_s = reload_s;
                    nxt_move_s   = 8'd0;
                end else begin
                    nxt_move_s   = move_cnt_r - 8'd1;
                end
            end
            ST_RETREAT: begin
                if (at_limit_s) begin
                    nxt_state_s  = ST_JUMP;
                    nxt_jump_s   = JUMP_FRAMES;
                    nxt_move_s   = 8'd0;
                end else if (move_cnt_r <= 8'd1) begin
                    nxt_state_s  = ST_OBSERVE;
                    nxt_decide_s = reload_s;
                    nxt_move_s   = 8'd0;
                end else begin
                    nxt_move_s   = move_cnt_r - 8'd1;
                end
            end
            ST_JUMP: begin
                if (jump_cnt_r <= 8'd1) begin
                    nxt_state_s  = ST_OBSERVE;
                    nxt_decide_s = reload_s;
                    nxt_jump_s   = 8'd0;
                end else begin
                    nxt_jump_s   = jump_cnt_r - 8'd1;
                end
            end
            ST_FIRE: begin
                nxt_state_s  = ST_OBSERVE;
                nxt_decide_s = reload_s;
                nxt_cool_s   = FIRE_COOLDOWN;
            end
            default: begin
                nxt_state_s  = ST_IDLE;
                nxt_decide_s = 8'd0;
                nxt_move_s   = 8'd0;
                nxt_jump_s   = 8'd0;
                nxt_cool_s   = 8'd0;
            end
        endcase
    end

    // Output decode from the state being entered; at most one level is ever set.
    always_comb begin
        left_s  = 1'b0;
        right_s = 1'b0;
        up_s    = 1'b0;
        shoot_s = 1'b0;
        case (nxt_state_s)
            ST_APPROACH: begin
                left_s  = right_of_s;
                right_s = ~right_of_s;
            end
            ST_RETREAT: begin
                left_s  = ~right_of_s;
                right_s = right_of_s;
            end
            ST_JUMP:  up_s    = 1'b1;
            ST_FIRE:  shoot_s = 1'b1;
            default:  up_s    = 1'b0;
        endcase
    end

    // FSM, counters and output registers; leaving battle forces everything idle at once.
    always_ff @(posedge Clk) begin
        if (Reset || !enable) begin
            state_r      <= ST_IDLE;
            decide_cnt_r <= 8'd0;
            move_cnt_r   <= 8'd0;
            jump_cnt_r   <= 8'd0;
            cooldown_r   <= 8'd0;
            NPC_Left     <= 1'b0;
            NPC_Right    <= 1'b0;
            NPC_Up       <= 1'b0;
            NPC_Shoot    <= 1'b0;
        end else if (tick_s) begin
            state_r      <= nxt_state_s;
            decide_cnt_r <= nxt_decide_s;
            move_cnt_r   <= nxt_move_s;
            jump_cnt_r   <= nxt_jump_s;
            cooldown_r   <= nxt_cool_s;
            NPC_Left     <= left_s;
            NPC_Right    <= right_s;
            NPC_Up       <= up_s;
            NPC_Shoot    <= shoot_s;
        end else begin
            state_r      <= state_r;
            decide_cnt_r <= decide_cnt_r;
            move_cnt_r   <= move_cnt_r;
            jump_cnt_r   <= jump_cnt_r;
            cooldown_r   <= cooldown_r;
            NPC_Left     <= NPC_Left;
            NPC_Right    <= NPC_Right;
            NPC_Up       <= NPC_Up;
            NPC_Shoot    <= NPC_Shoot;
        end
    end

    assign state_dbg = state_r;

endmodule

// File: tb/tb_npc_ai_controller.sv
// Scoreboard bench for npc_ai_controller: a frame-level reference model queues the
// expected outputs per frame, and a monitor compares them against the DUT when due.
module tb_npc_ai_controller;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       enable;
    logic [9:0] NPC_X;
    logic [9:0] Player_X;
    logic       NPC_Left;
    logic       NPC_Right;
    logic       NPC_Up;
    logic       NPC_Shoot;
    logic [2:0] state_dbg;

    npc_ai_controller dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .enable    (enable),
        .NPC_X     (NPC_X),
        .Player_X  (Player_X),
        .NPC_Left  (NPC_Left),
        .NPC_Right (NPC_Right),
        .NPC_Up    (NPC_Up),
        .NPC_Shoot (NPC_Shoot),
        .state_dbg (state_dbg)
    );

    always #10 Clk = ~Clk;

`ifdef NPC_AI_RANDOM_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    localparam int S_IDLE = 0, S_OBS = 1, S_APP = 2, S_RET = 3, S_JUMP = 4, S_FIRE = 5;
    localparam int FRAME_LEN = 100;

    typedef struct {
        logic [6:0] exp;
        int         due;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   finish_req = 1'b0;
    bit   mon_done = 1'b0;

    // Reference model state, in frames and plain integers.
    int       m_state, m_decide, m_move, m_jump, m_cool;
    bit       m_l, m_r, m_u, m_s;
    bit [15:0] m_lfsr;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [6:0] cur_exp();
        return {3'(m_state), m_l, m_r, m_u, m_s};
    endfunction

    task automatic push(input int due, input string tag);
        exp_t e;
        e.exp = cur_exp();
        e.due = due;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        m_state = S_IDLE; m_decide = 0; m_move = 0; m_jump = 0; m_cool = 0;
        m_l = 1'b0; m_r = 1'b0; m_u = 1'b0; m_s = 1'b0;
    endtask

    // One frame of behaviour, from the rules: pick the state entered at this tick.
    task automatic model_frame(input int npc, input int ply);
        int d;
        int reload;
        int cool_n;
        bit ro;
        bit lim;
        d = npc - ply;
        if (d < 0) d = -d;
        ro = (npc >= ply);
        lim = ro ? (npc >= 590) : (npc <= 10);
        reload = 8 + (RND ? int'(m_lfsr[2:0]) : 0);
        if (enable) begin
            cool_n = (m_state != S_IDLE && m_cool > 0) ? m_cool - 1 : m_cool;
            case (m_state)
                S_IDLE: begin m_state = S_OBS; m_decide = 8; end
                S_OBS: begin
                    m_decide = m_decide - 1;
                    if (m_decide == 0) begin
                        if (d < 40) begin
                            if (lim) begin m_state = S_JUMP; m_jump = 2; end
                            else begin m_state = S_RET; m_move = 16; end
                        end else if (m_cool == 0 && d <= 120) m_state = S_FIRE;
                        else if (d > 120) begin m_state = S_APP; m_move = 16; end
                        else if (RND && m_lfsr[3]) begin m_state = S_JUMP; m_jump = 2; end
                        else m_decide = reload;
                    end
                end
                S_APP: begin
                    m_move = m_move - 1;
                    if (m_move == 0 || d <= 120) begin m_state = S_OBS; m_decide = reload; end
                end
                S_RET: begin
                    m_move = m_move - 1;
                    if (lim) begin m_state = S_JUMP; m_jump = 2; end
                    else if (m_move == 0) begin m_state = S_OBS; m_decide = reload; end
                end
                S_JUMP: begin
                    m_jump = m_jump - 1;
                    if (m_jump == 0) begin m_state = S_OBS; m_decide = reload; end
                end
                S_FIRE: begin m_state = S_OBS; m_decide = reload; cool_n = 90; end
                default: m_state = S_IDLE;
            endcase
            m_cool = cool_n;
            m_l = (m_state == S_APP && ro) || (m_state == S_RET && !ro);
            m_r = (m_state == S_APP && !ro) || (m_state == S_RET && ro);
            m_u = (m_state == S_JUMP);
            m_s = (m_state == S_FIRE);
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic do_frame(input int npc, input int ply);
        NPC_X = 10'(npc);
        Player_X = 10'(ply);
        frame_clk = 1'b1;
        model_frame(npc, ply);
        push(cyc + 5, "tick");
        push(cyc + FRAME_LEN - 1, "hold");
        repeat (FRAME_LEN / 2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (FRAME_LEN / 2) @(negedge Clk);
    endtask

    task automatic run(input int npc, input int ply, input int n);
        for (int i = 0; i < n; i++) do_frame(npc, ply);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_clear();
        m_lfsr = 16'hACE1;
        push(cyc + 1, "reset");
        push(cyc + 40, "pre_tick");
        repeat (45) @(negedge Clk);
    endtask

    task automatic drop_enable();
        enable = 1'b0;
        model_clear();
        push(cyc + 1, "en_drop");
        repeat (5) @(negedge Clk);
    endtask

    task automatic raise_enable();
        enable = 1'b1;
        push(cyc + 3, "re_enable");
        repeat (5) @(negedge Clk);
    endtask

    task automatic quiet(input int n);
        push(cyc + 1, "quiet_start");
        push(cyc + n, "quiet_end");
        repeat (n + 2) @(negedge Clk);
    endtask

    // Monitor: exclusivity of the output levels every cycle, scoreboard entries when due.
    initial begin : monitor
        exp_t       e;
        logic [6:0] got;
        while (!mon_done) begin
            @(negedge Clk);
            got = {state_dbg, NPC_Left, NPC_Right, NPC_Up, NPC_Shoot};
            checks++;
            if (int'(NPC_Left) + int'(NPC_Right) + int'(NPC_Up) + int'(NPC_Shoot) > 1) begin
                errors++;
                $display("FAIL onehot @cyc %0d: L=%b R=%b U=%b S=%b, required at most one set",
                         cyc, NPC_Left, NPC_Right, NPC_Up, NPC_Shoot);
            end
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (got !== e.exp) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got state=%0d LRUS=%b, required state=%0d LRUS=%b",
                             e.tag, cyc, got[6:4], got[3:0], e.exp[6:4], e.exp[3:0]);
                end
            end
            if (finish_req) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL drain: %0d expectations never reached, required 0", exp_q.size());
                end
                mon_done = 1'b1;
            end
        end
    end

    initial begin : stimulus
        int npc;
        int ply;
        Reset = 1'b1;
        frame_clk = 1'b0;
        enable = 1'b1;
        NPC_X = 10'd0;
        Player_X = 10'd0;
        @(negedge Clk);

        do_reset(); run(500, 260, 9); run(380, 260, 3);
        do_reset(); run(360, 260, 115);
        do_reset(); run(280, 260, 30);
        do_reset(); run(595, 580, 14);
        do_reset(); run(5, 20, 12);
        do_reset(); run(300, 260, 12); run(300, 300, 12);

        do_reset(); run(360, 260, 12);
        drop_enable(); run(360, 260, 2); raise_enable(); run(360, 260, 10);
        run(100, 400, 12);
        drop_enable(); run(100, 400, 1); raise_enable(); run(100, 400, 2);
        quiet(1000);

        do_reset();
        npc = 300;
        ply = 300;
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                ply = int'($urandom_range(0, 600));
                npc = ply + int'($urandom_range(0, 320)) - 160;
                if (npc < 0) npc = 0;
                if (npc > 600) npc = 600;
            end
            if (enable && $urandom_range(0, 39) == 0) drop_enable();
            else if (!enable && $urandom_range(0, 2) == 0) raise_enable();
            do_frame(npc, ply);
        end

        repeat (3) @(negedge Clk);
        finish_req = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
